// File: rtl/adc_channel_sequencer.sv
// Round-robin ADC channel scheduler: walks the enabled-channel mask, waits for a
// tagged conversion result per channel, republishes it, and skips silent channels.
module adc_channel_sequencer #(
    parameter int unsigned NUM_CH         = 8,
    parameter int unsigned SAMPLE_W       = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   i_en_mask,
    output logic [3:0]          o_channel,
    input  logic                i_new_sample,
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic [3:0]          i_sample_channel,
    output logic                o_out_valid,
    output logic [3:0]          o_out_channel,
    output logic [SAMPLE_W-1:0] o_out_sample,
    output logic                o_timeout_err,
    output logic                o_busy
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StWait
    } state_t;

    state_t                r_state;
    logic [3:0]            r_ptr;
    logic [3:0]            r_cur_ch;
    logic [TW-1:0]         r_timer;
    logic [3:0]            r_channel;
    logic                  r_out_valid;
    logic [3:0]            r_out_channel;
    logic [SAMPLE_W-1:0]   r_out_sample;
    logic                  r_timeout_err;
    logic                  r_busy;

    logic [15:0]           w_mask16;
    logic                  w_any;
    logic [3:0]            w_next_ch;

    assign w_mask16 = 16'(i_en_mask);
    assign w_any    = |i_en_mask;

    // First enabled bit strictly after r_ptr, wrapping; falls back to r_ptr itself.
    always_comb begin
        logic [4:0] v_sum;
        logic       v_found;
        v_sum     = '0;
        v_found   = 1'b0;
        w_next_ch = r_ptr;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            v_sum = 5'(r_ptr) + 5'(k);
            if (v_sum >= 5'(NUM_CH)) begin
                v_sum = v_sum - 5'(NUM_CH);
            end
            if (!v_found && w_mask16[v_sum[3:0]]) begin
                w_next_ch = v_sum[3:0];
                v_found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_ptr         <= 4'(NUM_CH - 1);
            r_cur_ch      <= '0;
            r_timer       <= '0;
            r_channel     <= 4'hF;
            r_out_valid   <= 1'b0;
            r_out_channel <= '0;
            r_out_sample  <= '0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_out_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_channel <= 4'hF;
                    if (w_any) begin
                        r_state <= StArm;
                        r_busy  <= 1'b1;
                    end
                end
                StArm: begin
                    if (!w_any) begin
                        r_state   <= StIdle;
                        r_channel <= 4'hF;
                        r_busy    <= 1'b0;
                    end else begin
                        r_cur_ch  <= w_next_ch;
                        r_channel <= w_next_ch;
                        r_timer   <= '0;
                        r_state   <= StWait;
                    end
                end
                StWait: begin
                    // Mask clear wins over capture, capture wins over timeout.
                    if (!w_mask16[r_cur_ch]) begin
                        r_ptr   <= r_cur_ch;
                        r_state <= StArm;
                    end else if (i_new_sample && (i_sample_channel == r_cur_ch)) begin
                        r_out_sample  <= i_sample;
                        r_out_channel <= r_cur_ch;
                        r_out_valid   <= 1'b1;
                        r_ptr         <= r_cur_ch;
                        r_state       <= StArm;
                    end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_ptr         <= r_cur_ch;
                        r_timeout_err <= 1'b1;
                        r_state       <= StArm;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_channel     = r_channel;
    assign o_out_valid   = r_out_valid;
    assign o_out_channel = r_out_channel;
    assign o_out_sample  = r_out_sample;
    assign o_timeout_err = r_timeout_err;
    assign o_busy        = r_busy;

endmodule
